// File: rtl/para_ctrl_pkg.sv
// para_ctrl_pkg: FSM states, section codes and load-size helpers shared by para_load_ctrl.
package para_ctrl_pkg;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_e;

    typedef enum logic [2:0] {
        SEC_RSIGN, SEC_BN_A, SEC_BN_B, SEC_BETA, SEC_GAMMA, SEC_ZETA
    } section_e;

    localparam int CH_SECTIONS = 5;

    function automatic int total_words(input int fm_depth, input int channel_num);
        return fm_depth + CH_SECTIONS * channel_num;
    endfunction

    // rsign words come first, then one section per channel_num words
    function automatic section_e section_of(input int k, input int fm_depth, input int channel_num);
        section_e s;
        s = SEC_RSIGN;
        for (int i = 0; i < CH_SECTIONS; i++)
            if (k >= fm_depth + i * channel_num) s = section_e'(3'(i + 1));
        return s;
    endfunction

endpackage

// File: rtl/para_checksum.sv
// para_checksum: modulo-2^W sum of delivered words, compared against the expected value at load end.
module para_checksum #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         add,
    input  logic         check,
    input  logic [W-1:0] data,
    input  logic [W-1:0] expected,
    output logic         chk_err
);

    logic [W-1:0] sum_q, sum_d, exp_q, exp_d;
    logic         err_q, err_d;

    always_comb begin
        sum_d = clr ? '0 : (add ? sum_q + data : sum_q);
        exp_d = clr ? expected : exp_q;
        err_d = clr ? 1'b0 : (check ? (sum_q != exp_q) : err_q);
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            sum_q <= '0;
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            exp_q <= exp_d;
            err_q <= err_d;
        end

    assign chk_err = err_q;

endmodule

// File: rtl/para_load_ctrl.sv
// para_load_ctrl: streams FM_DEPTH + 5*CHANNEL_NUM parameter words from memory to the loader.
// Define PARA_CHECKSUM_EN to add the delivered-word checksum (chk_expected / chk_err).
module para_load_ctrl
    import para_ctrl_pkg::*;
#(
    parameter int FM_DEPTH    = 64,
    parameter int CHANNEL_NUM = 128,
    parameter int PARA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  stall,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [PARA_WIDTH-1:0] mem_rd_data,
    output logic [PARA_WIDTH-1:0] para_out,
    output logic                  para_valid,
    output logic                  mode_out,
    output logic [2:0]            section,
    output logic                  busy,
`ifdef PARA_CHECKSUM_EN
    output logic                  done,
    input  logic [PARA_WIDTH-1:0] chk_expected,
    output logic                  chk_err
`else
    output logic                  done
`endif
);

    localparam int TOTAL = total_words(FM_DEPTH, CHANNEL_NUM);
    localparam int CNT_W = $clog2(TOTAL);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    state_e                state_q, state_d;
    section_e              section_q, section_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  valid_q, valid_d;
    logic                  issue;

    always_comb begin
        state_d   = state_q;
        section_d = section_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        issue     = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_FETCH;
                cnt_d   = '0;
                addr_d  = base_addr;
            end
            S_FETCH: if (!stall) begin
                issue     = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                addr_d    = addr_q + ADDR_WIDTH'(1);
                section_d = section_of(int'(cnt_q), FM_DEPTH, CHANNEL_NUM);
                state_d   = (cnt_q == LAST) ? S_DRAIN : S_FETCH;
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        valid_d = issue;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q   <= S_IDLE;
            section_q <= SEC_RSIGN;
            cnt_q     <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            section_q <= section_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
        end

    assign mem_rd_en  = issue;
    assign mem_addr   = addr_q;
    assign para_out   = mem_rd_data;
    assign para_valid = valid_q;
    assign section    = section_q;
    assign mode_out   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

`ifdef PARA_CHECKSUM_EN
    para_checksum #(.W(PARA_WIDTH)) u_checksum (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (state_q == S_IDLE && start),
        .add      (valid_q),
        .check    (state_q == S_DONE),
        .data     (mem_rd_data),
        .expected (chk_expected),
        .chk_err  (chk_err)
    );
`endif

endmodule

// File: tb/tb_para_load_ctrl.sv
// tb_para_load_ctrl: drives whole loads (clean, scripted stall, random stall, wrap, mid-load reset)
// and checks addresses, data, sections and handshakes against a word-index reference model.
module tb_para_load_ctrl;

    localparam int FM    = 64;
    localparam int CH    = 128;
    localparam int AW    = 16;
    localparam int PW    = 16;
    localparam int TOTAL = FM + 5 * CH;

    logic          clk = 1'b0;
    logic          rstn, start, stall;
    logic [AW-1:0] base_addr, mem_addr;
    logic          mem_rd_en, para_valid, mode_out, busy, done;
    logic [PW-1:0] mem_rd_data, para_out;
    logic [2:0]    section;
`ifdef PARA_CHECKSUM_EN
    logic [PW-1:0] chk_expected, chk_exp_v;
    logic          chk_err, chk_first;
`endif

    always #5 clk = ~clk;

    para_load_ctrl #(.FM_DEPTH(FM), .CHANNEL_NUM(CH), .PARA_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .base_addr   (base_addr),
        .stall       (stall),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .para_out    (para_out),
        .para_valid  (para_valid),
        .mode_out    (mode_out),
        .section     (section),
        .busy        (busy),
        .done        (done)
`ifdef PARA_CHECKSUM_EN
        , .chk_expected(chk_expected)
        , .chk_err     (chk_err)
`endif
    );

    // memory word at address a is a, returned one cycle after the read strobe
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr;

    typedef struct { int k; logic [2:0] sec; } sec_vec_t;
    typedef struct { logic [AW-1:0] base; int smode; logic [AW-1:0] last_addr; } load_vec_t;

    sec_vec_t      stbl[8];
    load_vec_t     ltbl[3];
    logic [AW-1:0] rd_q[$];
    logic [PW-1:0] dat_q[$];
    logic [2:0]    sec_q[$];
    int  cyc = 0, done_n = 0, pv_bad = 0, mode_bad = 0, busy_n = 0;
    int  last_rd_cyc = 0, done_cyc = 0, acc_cyc = 0;
    int  n_chk = 0, n_fail = 0;
    logic prev_rd = 1'b0;

    function automatic bit check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int ref_sec(input int k);
        return (k < FM) ? 0 : 1 + (k - FM) / CH;
    endfunction

`ifdef PARA_CHECKSUM_EN
    function automatic logic [PW-1:0] ref_sum(input logic [AW-1:0] b);
        logic [PW-1:0] s;
        s = '0;
        for (int k = 0; k < TOTAL; k++) s = s + PW'(b + AW'(k));
        return s;
    endfunction
`endif

    always @(negedge clk) begin
        cyc++;
        if (start && !busy) acc_cyc = cyc;
        if (mem_rd_en) begin
            rd_q.push_back(mem_addr);
            last_rd_cyc = cyc;
        end
        if (para_valid) begin
            dat_q.push_back(para_out);
            sec_q.push_back(section);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (busy) busy_n++;
        if (para_valid !== prev_rd) pv_bad++;
        if (mode_out !== !busy) mode_bad++;
        prev_rd = mem_rd_en;
    end

    task automatic check_idle(input string tag);
        void'(check({tag, "_mode_out"}, 32'(mode_out), 32'd1));
        void'(check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0));
        void'(check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0));
        void'(check({tag, "_para_valid"}, 32'(para_valid), 32'd0));
        void'(check({tag, "_section"}, 32'(section), 32'd0));
        void'(check({tag, "_busy"}, 32'(busy), 32'd0));
        void'(check({tag, "_done"}, 32'(done), 32'd0));
`ifdef PARA_CHECKSUM_EN
        void'(check({tag, "_chk_err"}, 32'(chk_err), 32'd0));
`endif
    endtask

    task automatic begin_load(input logic [AW-1:0] b);
        rd_q.delete();
        dat_q.delete();
        sec_q.delete();
        done_n = 0; pv_bad = 0; mode_bad = 0; busy_n = 0;
        acc_cyc = 0; last_rd_cyc = 0; done_cyc = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
`ifdef PARA_CHECKSUM_EN
        chk_expected = chk_exp_v;
`endif
    endtask

    task automatic check_load(input load_vec_t v);
        void'(check("n_reads", rd_q.size(), TOTAL));
        for (int k = 0; k < rd_q.size(); k++)
            if (!check($sformatf("addr_k%0d", k), 32'(rd_q[k]), 32'(AW'(v.base + AW'(k))))) break;
        if (rd_q.size() > 0) void'(check("last_addr", 32'(rd_q[rd_q.size() - 1]), 32'(v.last_addr)));
        void'(check("n_valid", dat_q.size(), TOTAL));
        for (int k = 0; k < dat_q.size(); k++)
            if (!check($sformatf("data_k%0d", k), 32'(dat_q[k]), 32'(PW'(v.base + AW'(k))))) break;
        for (int k = 0; k < sec_q.size(); k++)
            if (!check($sformatf("section_k%0d", k), 32'(sec_q[k]), ref_sec(k))) break;
        foreach (stbl[i])
            if (stbl[i].k < sec_q.size())
                void'(check($sformatf("sec_boundary_k%0d", stbl[i].k), 32'(sec_q[stbl[i].k]), 32'(stbl[i].sec)));
        void'(check("done_pulses", done_n, 1));
        void'(check("done_after_last_read", done_cyc - last_rd_cyc, 2));
        void'(check("busy_cycles", busy_n, done_cyc - acc_cyc));
        void'(check("valid_follows_rd", pv_bad, 0));
        void'(check("mode_vs_busy", mode_bad, 0));
`ifdef PARA_CHECKSUM_EN
        void'(check("chk_cleared_on_start", 32'(chk_first), 32'd0));
        void'(check("chk_err", 32'(chk_err), 32'(ref_sum(v.base) != chk_exp_v)));
`endif
    endtask

    // smode: 0 no stall, 1 random stall, 2 five-cycle stalls at k=100 and on the last read, plus stall in DRAIN
    task automatic run_load(input load_vec_t v);
        int stall_left = 0;
        bit s100 = 1'b0, slast = 1'b0;
        int n;
        begin_load(v.base);
        for (int c = 0; c < 4 * TOTAL && done_n == 0; c++) begin
            @(posedge clk);
            #1;
            n = rd_q.size();
            start = 1'($urandom_range(0, 1));
            base_addr = AW'($urandom);
`ifdef PARA_CHECKSUM_EN
            if (c == 0) chk_first = chk_err;
            chk_expected = PW'($urandom);
`endif
            if (v.smode == 1) stall = ($urandom_range(0, 2) == 0);
            else if (v.smode == 2) begin
                if (stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                end else if ((n == 100 && !s100) || (n == TOTAL - 1 && !slast)) begin
                    stall = 1'b1;
                    stall_left = 4;
                    if (n == 100) s100 = 1'b1;
                    else slast = 1'b1;
                end else stall = (n == TOTAL);
            end else stall = 1'b0;
        end
        start = 1'b0;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        check_load(v);
    endtask

    initial begin
        load_vec_t v;
        stbl = '{'{0, 3'd0}, '{63, 3'd0}, '{64, 3'd1}, '{191, 3'd1},
                 '{192, 3'd2}, '{575, 3'd4}, '{576, 3'd5}, '{703, 3'd5}};
        ltbl = '{'{16'h0100, 0, 16'h03BF}, '{16'h0100, 2, 16'h03BF}, '{16'hFFF0, 1, 16'h02AF}};
        rstn = 1'b0; start = 1'b0; stall = 1'b0; base_addr = '0;
`ifdef PARA_CHECKSUM_EN
        chk_expected = '0; chk_exp_v = '0; chk_first = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_idle("reset");
        rstn = 1'b1;
        @(negedge clk);
        check_idle("idle");

        foreach (ltbl[i]) begin
`ifdef PARA_CHECKSUM_EN
            chk_exp_v = PW'($urandom);
`endif
            run_load(ltbl[i]);
        end

        for (int r = 0; r < 2; r++) begin
            v.base = AW'($urandom);
            v.smode = 1;
            v.last_addr = v.base + AW'(TOTAL - 1);
            run_load(v);
        end

        // abort a load at word 300 with reset, then restart from word 0
        begin_load(16'h0200);
        for (int c = 0; c < 2 * TOTAL && rd_q.size() < 300; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stall = 1'b0;
        end
        void'(check("reads_before_abort", rd_q.size(), 300));
        rstn = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        repeat (2) @(negedge clk);
        void'(check("mode_out_in_reset", 32'(mode_out), 32'd1));
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        void'(check("no_done_after_abort", done_n, 0));
        run_load('{16'h0040, 0, 16'h02FF});

`ifdef PARA_CHECKSUM_EN
        chk_exp_v = ref_sum(16'h0000);
        run_load('{16'h0000, 0, 16'h02BF});
        chk_exp_v = 16'h0000;
        run_load('{16'h0000, 0, 16'h02BF});
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
